// File: rtl/axi_mem_tester.sv
// axi_mem_tester: AXI4 write-then-readback pattern tester for a DDR user port.
// Writes NUM_BURSTS bursts of address^SEED data, reads them back, counts errors.
module axi_mem_tester #(
   parameter logic [29:0] BASE_ADDR  = 30'd0,
   parameter int          BURST_LEN  = 16,
   parameter int          NUM_BURSTS = 64,
   parameter logic [31:0] SEED       = 32'hA5A5A5A5
) (
   input  logic        ui_clk,
   input  logic        aresetn,
   input  logic        init_calib_complete,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [3:0]  m_axi_awid,
   output logic [29:0] m_axi_awaddr,
   output logic [7:0]  m_axi_awlen,
   output logic [2:0]  m_axi_awsize,
   output logic [1:0]  m_axi_awburst,
   output logic        m_axi_awlock,
   output logic [3:0]  m_axi_awcache,
   output logic [2:0]  m_axi_awprot,
   output logic [3:0]  m_axi_awqos,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   output logic        m_axi_wlast,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   input  logic [1:0]  m_axi_bresp,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic [3:0]  m_axi_arid,
   output logic [29:0] m_axi_araddr,
   output logic [7:0]  m_axi_arlen,
   output logic [2:0]  m_axi_arsize,
   output logic [1:0]  m_axi_arburst,
   output logic        m_axi_arlock,
   output logic [3:0]  m_axi_arcache,
   output logic [2:0]  m_axi_arprot,
   output logic [3:0]  m_axi_arqos,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   input  logic [31:0] m_axi_rdata,
   input  logic [1:0]  m_axi_rresp,
   input  logic        m_axi_rlast,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready
);

   localparam logic [29:0] STEP     = 30'(BURST_LEN * 4);
   localparam logic [7:0]  LAST_B   = 8'(BURST_LEN - 1);
   localparam logic [15:0] LAST_BST = 16'(NUM_BURSTS - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_CAL, WR_ADDR, WR_DATA,
      WR_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   state_t      state;
   logic [29:0] addr;
   logic [29:0] beat_addr;
   logic [7:0]  beat;
   logic [15:0] burst_idx;
   logic [1:0]  r_errs;
   logic [15:0] err_rd;
   logic [31:0] exp_data;
   logic        last_beat;

   assign m_axi_awid    = 4'd0;
   assign m_axi_awlen   = LAST_B;
   assign m_axi_awsize  = 3'b010;
   assign m_axi_awburst = 2'b01;
   assign m_axi_awlock  = 1'b0;
   assign m_axi_awcache = 4'd0;
   assign m_axi_awprot  = 3'd0;
   assign m_axi_awqos   = 4'd0;
   assign m_axi_wstrb   = 4'hF;
   assign m_axi_arid    = 4'd0;
   assign m_axi_arlen   = LAST_B;
   assign m_axi_arsize  = 3'b010;
   assign m_axi_arburst = 2'b01;
   assign m_axi_arlock  = 1'b0;
   assign m_axi_arcache = 4'd0;
   assign m_axi_arprot  = 3'd0;
   assign m_axi_arqos   = 4'd0;
   assign m_axi_awaddr  = addr;
   assign m_axi_araddr  = addr;

   function automatic logic [15:0] sat_add(
      input logic [15:0] a,
      input logic [1:0]  b
   );
      logic [16:0] s;
      s = {1'b0, a} + {15'd0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   assign exp_data  = {2'b00, beat_addr} ^ SEED;
   assign last_beat = (beat == LAST_B);

   // data/resp fault and rlast fault are counted independently
   always_comb begin
      r_errs = 2'd0;
      if ((m_axi_rdata != exp_data) || (m_axi_rresp != 2'b00))
         r_errs = r_errs + 2'd1;
      if (m_axi_rlast != last_beat)
         r_errs = r_errs + 2'd1;
   end

   assign err_rd = sat_add(err_count, r_errs);

   always_ff @(posedge ui_clk or negedge aresetn) begin
      if (!aresetn) begin
         state         <= IDLE;
         addr          <= BASE_ADDR;
         beat_addr     <= BASE_ADDR;
         beat          <= 8'd0;
         burst_idx     <= 16'd0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= 16'd0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wlast   <= 1'b0;
         m_axi_wdata   <= 32'd0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  err_count <= 16'd0;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  busy      <= 1'b1;
                  burst_idx <= 16'd0;
                  addr      <= BASE_ADDR;
                  state     <= WAIT_CAL;
               end
            end
            WAIT_CAL: begin
               if (init_calib_complete) begin
                  m_axi_awvalid <= 1'b1;
                  state         <= WR_ADDR;
               end
            end
            WR_ADDR: begin
               if (m_axi_awready) begin
                  m_axi_awvalid <= 1'b0;
                  m_axi_wvalid  <= 1'b1;
                  m_axi_wdata   <= {2'b00, addr} ^ SEED;
                  m_axi_wlast   <= (BURST_LEN == 1);
                  beat_addr     <= addr;
                  beat          <= 8'd0;
                  state         <= WR_DATA;
               end
            end
            WR_DATA: begin
               if (m_axi_wready) begin
                  if (last_beat) begin
                     m_axi_wvalid <= 1'b0;
                     m_axi_wlast  <= 1'b0;
                     m_axi_bready <= 1'b1;
                     state        <= WR_RESP;
                  end else begin
                     beat        <= beat + 8'd1;
                     beat_addr   <= beat_addr + 30'd4;
                     m_axi_wdata <= {2'b00, beat_addr + 30'd4} ^ SEED;
                     m_axi_wlast <= ((beat + 8'd1) == LAST_B);
                  end
               end
            end
            WR_RESP: begin
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  if (m_axi_bresp != 2'b00)
                     err_count <= sat_add(err_count, 2'd1);
                  if (burst_idx == LAST_BST) begin
                     burst_idx     <= 16'd0;
                     addr          <= BASE_ADDR;
                     m_axi_arvalid <= 1'b1;
                     state         <= RD_ADDR;
                  end else begin
                     burst_idx     <= burst_idx + 16'd1;
                     addr          <= addr + STEP;
                     m_axi_awvalid <= 1'b1;
                     state         <= WR_ADDR;
                  end
               end
            end
            RD_ADDR: begin
               if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  beat          <= 8'd0;
                  beat_addr     <= addr;
                  state         <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m_axi_rvalid) begin
                  err_count <= err_rd;
                  beat      <= beat + 8'd1;
                  beat_addr <= beat_addr + 30'd4;
                  if (last_beat) begin
                     m_axi_rready <= 1'b0;
                     if (burst_idx == LAST_BST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_rd == 16'd0);
                        state <= DONE;
                     end else begin
                        burst_idx     <= burst_idx + 16'd1;
                        addr          <= addr + STEP;
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_ADDR;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_mem_tester.sv
// tb_axi_mem_tester: AXI slave memory model with scoreboard queues,
// directed passes for ideal, corrupted, stalled, late-cal and reset cases.
module tb_axi_mem_tester;

   localparam int          BL   = 4;
   localparam int          NB   = 2;
   localparam logic [31:0] SEED = 32'hA5A5A5A5;

   logic        ui_clk = 1'b0;
   logic        aresetn = 1'b0;
   logic        init_calib_complete = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, pass;
   logic [15:0] err_count;
   logic [3:0]  awid, arid, awcache, arcache, awqos, arqos, wstrb;
   logic [29:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize, awprot, arprot;
   logic [1:0]  awburst, arburst;
   logic        awlock, arlock;
   logic        awvalid, wvalid, wlast, bready, arvalid, rready;
   logic [31:0] wdata;
   logic        awready = 0, wready = 0, arready = 0;
   logic        bvalid = 0, rvalid = 0, rlast = 0;
   logic [1:0]  bresp = 0, rresp = 0;
   logic [31:0] rdata = 0;

   axi_mem_tester #(
      .BURST_LEN(BL), .NUM_BURSTS(NB), .SEED(SEED)
   ) dut (
      .ui_clk(ui_clk), .aresetn(aresetn),
      .init_calib_complete(init_calib_complete),
      .start(start), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
      .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_awlock(awlock), .m_axi_awcache(awcache),
      .m_axi_awprot(awprot), .m_axi_awqos(awqos),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
      .m_axi_arsize(arsize), .m_axi_arburst(arburst),
      .m_axi_arlock(arlock), .m_axi_arcache(arcache),
      .m_axi_arprot(arprot), .m_axi_arqos(arqos),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   initial forever #5 ui_clk = ~ui_clk;

   int total = 0;
   int bad = 0;

   logic [29:0] exp_aw[$];
   logic [29:0] exp_ar[$];
   logic [31:0] exp_w[$];
   logic [29:0] wr_q[$];
   logic [29:0] rd_q[$];
   logic [31:0] mem[int];

   bit stall_en = 0, flip_en = 0, berr_en = 0;
   bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
   bit aw_prev, w_prev, ar_prev, r_act;
   logic [29:0] aw_pay, ar_pay, r_addr;
   logic [32:0] w_pay;
   int wbeat, b_pend, b_cnt, aw_cnt, ar_cnt, rbeat, r_burst;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_aw.delete(); exp_ar.delete(); exp_w.delete();
      wr_q.delete(); rd_q.delete();
      aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
      aw_prev = 0; w_prev = 0; ar_prev = 0; r_act = 0;
      wbeat = 0; b_pend = 0; b_cnt = 0; aw_cnt = 0; ar_cnt = 0;
      rbeat = 0; r_burst = 0;
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; rvalid = 0; rlast = 0; bresp = 0; rresp = 0; rdata = 0;
   endtask

   function automatic bit rnd_ok();
      return !stall_en || ($urandom_range(0, 1) == 1);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [29:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : 32'hDEADBEEF;
   endfunction

   // slave model: decisions taken at negedge, handshakes land on next posedge
   initial forever begin
      @(negedge ui_clk);
      if (aresetn) begin
         if (aw_prev) check("aw_stable", {awvalid, 1'b0, awaddr},
                            {1'b1, 1'b0, aw_pay});
         if (w_prev) check("w_stable", {wvalid, wlast, wdata[29:0]},
                           {1'b1, w_pay[32], w_pay[29:0]});
         if (ar_prev) check("ar_stable", {arvalid, 1'b0, araddr},
                            {1'b1, 1'b0, ar_pay});
         if (b_hs) begin
            b_hs = 0; bvalid = 0; b_pend--;
         end
         if (r_hs) begin
            r_hs = 0; rvalid = 0; rbeat++;
            if (rbeat == BL) begin
               r_act = 0; r_burst++;
            end
         end
         awready = rnd_ok();
         wready  = rnd_ok();
         arready = rnd_ok();
         if (!bvalid && b_pend > 0 && rnd_ok()) begin
            bvalid = 1;
            bresp  = (berr_en && b_cnt == 0) ? 2'd2 : 2'd0;
            b_cnt++;
         end
         if (!r_act && rd_q.size() > 0) begin
            r_addr = rd_q.pop_front(); r_act = 1; rbeat = 0;
         end
         if (r_act && !rvalid && rnd_ok()) begin
            rvalid = 1;
            rdata  = mem_rd(r_addr + 30'(4 * rbeat));
            if (flip_en && r_burst == 1 && rbeat == 2) rdata[0] = ~rdata[0];
            rlast  = (rbeat == BL - 1);
            rresp  = 2'd0;
         end
         aw_hs = awvalid && awready;
         if (aw_hs) begin
            check("aw_expected", exp_aw.size() > 0, 1);
            if (exp_aw.size() > 0) check("awaddr", awaddr, exp_aw.pop_front());
            wr_q.push_back(awaddr);
            aw_cnt++;
         end
         w_hs = wvalid && wready;
         if (w_hs) begin
            check("w_after_aw", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) mem[int'(wr_q[0] + 30'(4 * wbeat))] = wdata;
            check("w_expected", exp_w.size() > 0, 1);
            if (exp_w.size() > 0) check("wdata", wdata, exp_w.pop_front());
            check("wlast", wlast, wbeat == BL - 1);
            wbeat++;
            if (wbeat == BL) begin
               wbeat = 0; b_pend++;
               if (wr_q.size() > 0) void'(wr_q.pop_front());
            end
         end
         ar_hs = arvalid && arready;
         if (ar_hs) begin
            check("ar_expected", exp_ar.size() > 0, 1);
            if (exp_ar.size() > 0) check("araddr", araddr, exp_ar.pop_front());
            rd_q.push_back(araddr);
            ar_cnt++;
         end
         b_hs = bvalid && bready;
         r_hs = rvalid && rready;
         aw_prev = awvalid && !aw_hs; aw_pay = awaddr;
         w_prev  = wvalid && !w_hs;   w_pay  = {wlast, wdata};
         ar_prev = arvalid && !ar_hs; ar_pay = araddr;
      end
   end

   task automatic push_exp();
      logic [29:0] a;
      for (int k = 0; k < NB; k++) begin
         a = 30'(k * BL * 4);
         exp_aw.push_back(a);
         exp_ar.push_back(a);
         for (int b = 0; b < BL; b++)
            exp_w.push_back({2'b00, a + 30'(4 * b)} ^ SEED);
      end
   endtask

   task automatic pulse_start();
      @(negedge ui_clk); start = 1;
      @(negedge ui_clk); start = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 3000) begin
         @(negedge ui_clk); n++;
      end
      check("done_timeout", done, 1);
   endtask

   task automatic check_end(input string tag, input int e);
      repeat (5) @(negedge ui_clk);
      check({tag, "_done"}, done, 1);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_pass"}, pass, e == 0);
      check({tag, "_errs"}, err_count, 32'(e));
      check({tag, "_aw_cnt"}, aw_cnt, NB);
      check({tag, "_ar_cnt"}, ar_cnt, NB);
      check({tag, "_w_left"}, exp_w.size(), 0);
      check({tag, "_idle_hs"}, {awvalid, wvalid, arvalid, bready, rready}, 0);
   endtask

   task automatic run_pass(input string tag, input int e);
      model_reset();
      push_exp();
      pulse_start();
      wait_done();
      check_end(tag, e);
   endtask

   initial begin
      bit seen;
      int n;
      model_reset();
      repeat (3) @(negedge ui_clk);
      check("rst_status", {busy, done, pass}, 0);
      check("rst_errs", err_count, 0);
      check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
      aresetn = 1;
      init_calib_complete = 1;
      @(negedge ui_clk);
      check("const_len", {awlen, arlen}, {8'd3, 8'd3});
      check("const_size_burst", {awsize, awburst, arsize, arburst},
            {3'b010, 2'b01, 3'b010, 2'b01});
      check("const_misc", {wstrb, awid, arid, awlock, arlock},
            {4'hF, 4'd0, 4'd0, 2'b00});

      run_pass("ideal", 0);

      flip_en = 1;
      run_pass("flip", 1);
      flip_en = 0;

      init_calib_complete = 0;
      model_reset();
      push_exp();
      pulse_start();
      seen = 0;
      repeat (100) begin
         @(negedge ui_clk);
         if (awvalid) seen = 1;
      end
      check("cal_hold_aw", seen, 0);
      check("cal_busy", busy, 1);
      init_calib_complete = 1;
      wait_done();
      check_end("late_cal", 0);

      stall_en = 1;
      model_reset();
      push_exp();
      pulse_start();
      repeat (6) @(negedge ui_clk);
      start = 1;
      @(negedge ui_clk);
      start = 0;
      wait_done();
      check_end("stall", 0);

      berr_en = 1;
      run_pass("bresp", 1);
      berr_en = 0;
      stall_en = 0;

      model_reset();
      push_exp();
      pulse_start();
      n = 0;
      while (!wvalid && n < 200) begin
         @(negedge ui_clk); n++;
      end
      check("reach_wr_data", wvalid, 1);
      @(posedge ui_clk);
      #1 aresetn = 0;
      #1;
      check("arst_valids", {awvalid, wvalid}, 0);
      check("arst_busy", busy, 0);
      model_reset();
      @(negedge ui_clk);
      aresetn = 1;
      run_pass("after_rst", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
